sha3_byte_packer: RTL and testbench
===================================

SHA3_BYTE_PACKER -- requirements
Module: sha3_byte_packer

Interface
REQ-001 The block SHALL have no parameters; widths are fixed for the 64-bit word interface of the SHA3-512 core.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-low; reset==0 at a rising edge SHALL reset the block.
REQ-004 byte_in  input  8  message byte from the source.
REQ-005 byte_valid  input  1  byte_in holds a valid byte.
REQ-006 byte_last  input  1  qualified by byte_valid; this byte is the final message byte.
REQ-007 eom  input  1  end of message with no accompanying byte; used for empty messages and byte-less termination.
REQ-008 byte_ready  output  1  the block accepts byte_in, or eom, this cycle.
REQ-009 in  output  64  packed word to the core; first byte of a word in bits [63:56].
REQ-010 in_ready  output  1  word valid to the core.
REQ-011 is_last  output  1  final word of the message.
REQ-012 byte_num  output  3  valid bytes in the final word (0..7); meaningful only when is_last==1.
REQ-013 buffer_full  input  1  core back-pressure; a word is consumed when in_ready==1 and buffer_full==0.
REQ-014 done  output  1  the final word has been consumed by the core.

Function
REQ-015 Byte accept condition: byte_valid==1 and byte_ready==1.
REQ-016 Word accept condition: in_ready==1 and buffer_full==0.
REQ-017 Output slot: a single register holding {in, is_last, byte_num}, with in_ready as its occupancy flag.
REQ-018 byte_ready SHALL equal (state==FILL) && (in_ready==0 || buffer_full==0); it is combinational on buffer_full.
REQ-019 States SHALL be FILL, FLUSH and DONE, with 4-bit byte counter cnt (0..7) and 64-bit accumulator acc.
REQ-020 FILL, accepted byte, cnt<7, byte_last==0: byte written to acc bits [63-8*cnt -: 8], cnt+1.
REQ-021 FILL, accepted byte that is the 8th byte with byte_last==0: the full word SHALL be loaded into the slot at the same edge with is_last=0; acc cleared; cnt=0.
REQ-022 FILL, accepted byte with byte_last==1 that is byte k<8 of its word: the slot SHALL be loaded with that word, unused low bytes 0, is_last=1, byte_num=k; next state DONE.
REQ-023 FILL, accepted byte with byte_last==1 that is the 8th byte: the slot SHALL be loaded with the full word and is_last=0; next state FLUSH.
REQ-024 FLUSH: byte_ready=0; when the slot is empty or being consumed, it SHALL be loaded with in=0, is_last=1, byte_num=0; next state DONE.
REQ-025 eom SHALL be acted on only in FILL when byte_valid==0 and byte_ready==1. It loads acc with is_last=1 and byte_num=cnt (0..7); next state DONE.
REQ-026 eom while byte_valid==1 SHALL be ignored; byte_last is the termination path.
REQ-027 Latency: a word SHALL appear on in/in_ready at the edge on which its final byte, eom or FLUSH is accepted, i.e. one cycle after the byte is presented.
REQ-028 A slot loaded while its previous word is consumed in the same cycle SHALL keep in_ready=1 with no bubble; throughput is 1 byte/cycle.
REQ-029 in, is_last and byte_num SHALL stay stable while in_ready==1 and buffer_full==1.
REQ-030 is_last SHALL be 0 whenever in_ready==0.
REQ-031 DONE: byte_ready=0 and all inputs ignored; done=1 once the slot is empty; the block stays in DONE until reset.

Reset
REQ-032 On reset==0: state=FILL, cnt=0, acc=0, in_ready=0, in=0, is_last=0, byte_num=0, done=0.
REQ-033 Reset mid-message SHALL discard the partial word and the slot contents with no word emitted; byte_ready SHALL go to 1 in the first cycle after reset releases.

Verification
REQ-034 Bytes 0x01..0x08, last on 0x08, buffer_full=0 -> word 0x0102030405060708 with is_last=0, then word 0 with is_last=1 and byte_num=0; done=1.
REQ-035 Bytes 0xAA,0xBB,0xCC, last on 0xCC -> one word 0xAABBCC0000000000 with is_last=1 and byte_num=3.
REQ-036 eom only, right after reset -> one word 0 with is_last=1 and byte_num=0.
REQ-037 20 bytes streamed with buffer_full high for 5 cycles during word 2 -> word held stable, byte_ready=0 while the slot is full, no byte lost; words 1-2 is_last=0, word 3 is_last=1 with byte_num=4.
REQ-038 reset=0 after 5 of 8 bytes, then bytes 0x11 (last) -> single word 0x1100000000000000 with is_last=1 and byte_num=1.
REQ-039 Bytes presented after done=1 -> byte_ready stays 0 and in_ready stays 0.

Source files
------------

// File: rtl/sha3_byte_packer.sv
// sha3_byte_packer
//   Packs a byte stream into 64-bit big-endian words for the SHA3-512 core.
//   The first byte of a word lands in bits [63:56]. A single output slot
//   holds {in, is_last, byte_num}, and in_ready marks the slot as occupied.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous reset, active-low
//   byte_in     message byte
//   byte_valid  byte_in is valid
//   byte_last   qualified by byte_valid; this is the final message byte
//   eom         end of message without a byte (only honoured when byte_valid==0)
//   byte_ready  byte_in / eom is accepted this cycle
//   in          packed word to the core
//   in_ready    word valid to the core
//   is_last     final word of the message
//   byte_num    valid bytes in the final word (0..7)
//   buffer_full core back-pressure; a word is consumed when in_ready && !buffer_full
//   done        the final word has been consumed
module sha3_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        eom,
    output logic        byte_ready,
    output logic [63:0] in,
    output logic        in_ready,
    output logic        is_last,
    output logic [2:0]  byte_num,
    input  logic        buffer_full,
    output logic        done
);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [63:0] acc;
    logic [63:0] merged;
    logic        slot_free;
    logic        consume;
    logic        byte_acc;
    logic        eom_acc;
    logic        cnt_is_7;

    assign consume   = in_ready && !buffer_full;
    // The slot can take a new word if it is empty or being drained this edge.
    assign slot_free = !in_ready || !buffer_full;
    assign byte_acc  = byte_valid && byte_ready;
    assign eom_acc   = eom && !byte_valid && byte_ready;
    assign cnt_is_7  = (cnt == 4'd7);

    // Accumulator with the incoming byte placed at position cnt.
    always_comb begin
        merged = acc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (cnt[2:0] == 3'(i))
                merged[63 - 8*i -: 8] = byte_in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= FILL;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (byte_acc && byte_last)
                    state_next = cnt_is_7 ? FLUSH : DONE;
                else if (eom_acc)
                    state_next = DONE;
            end
            FLUSH: begin
                if (slot_free)
                    state_next = DONE;
            end
            DONE:    state_next = DONE;
            default: state_next = FILL;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        byte_ready = (state == FILL) && slot_free;
        done       = (state == DONE) && !in_ready;
    end

    // Accumulator, counter and output slot
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            in       <= '0;
            in_ready <= 1'b0;
            is_last  <= 1'b0;
            byte_num <= '0;
        end else begin
            // Drain first; a load below overrides so back-to-back words have no bubble.
            if (consume) begin
                in_ready <= 1'b0;
                is_last  <= 1'b0;
            end
            case (state)
                FILL: begin
                    if (byte_acc) begin
                        if (byte_last || cnt_is_7) begin
                            in       <= merged;
                            in_ready <= 1'b1;
                            // A last byte that completes a word is followed by
                            // an empty terminating word from FLUSH.
                            is_last  <= byte_last && !cnt_is_7;
                            byte_num <= (byte_last && !cnt_is_7) ? cnt[2:0] + 3'd1 : 3'd0;
                            acc      <= '0;
                            cnt      <= '0;
                        end else begin
                            acc <= merged;
                            cnt <= cnt + 4'd1;
                        end
                    end else if (eom_acc) begin
                        in       <= acc;
                        in_ready <= 1'b1;
                        is_last  <= 1'b1;
                        byte_num <= cnt[2:0];
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        in       <= '0;
                        in_ready <= 1'b1;
                        is_last  <= 1'b1;
                        byte_num <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_byte_packer.sv
module tb_sha3_byte_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        eom;
    logic        byte_ready;
    logic [63:0] in;
    logic        in_ready;
    logic        is_last;
    logic [2:0]  byte_num;
    logic        buffer_full;
    logic        done;

    sha3_byte_packer dut (
        .clk         (clk),
        .reset       (reset),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_last   (byte_last),
        .eom         (eom),
        .byte_ready  (byte_ready),
        .in          (in),
        .in_ready    (in_ready),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .buffer_full (buffer_full),
        .done        (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [63:0] w;
        logic        l;
        logic [2:0]  n;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  cur_msg[$];
    int          tests = 0;
    int          errors = 0;
    int          stall_pct = 0;
    int          force_stall = 0;
    bit          mon_en = 0;
    bit          term = 0;
    bit          hold_valid = 0;
    exp_t        hold;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference: full 8-byte chunks are non-final words; the remainder
    // (possibly empty) forms the final word with byte_num = len % 8.
    task automatic model_push(input logic [7:0] msg[$]);
        int   full, rem;
        exp_t e;
        full = msg.size() / 8;
        rem  = msg.size() % 8;
        for (int w = 0; w < full; w++) begin
            e = '0;
            for (int j = 0; j < 8; j++) e.w = {e.w[55:0], msg[8*w + j]};
            expq.push_back(e);
        end
        e = '0;
        for (int j = 0; j < 8; j++) e.w = {e.w[55:0], (j < rem) ? msg[8*full + j] : 8'h00};
        e.l = 1'b1;
        e.n = 3'(rem);
        expq.push_back(e);
    endtask

    // Back-pressure generator
    always @(posedge clk) begin
        #2;
        if (force_stall > 0) begin
            buffer_full = 1'b1;
            force_stall--;
        end else begin
            buffer_full = ($urandom_range(99) < stall_pct);
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (mon_en) begin
            chk("byte_ready", {63'd0, byte_ready}, {63'd0, !term && (!in_ready || !buffer_full)});
            chk("done", {63'd0, done}, {63'd0, term && !in_ready && expq.size() == 0});
            if (!in_ready) chk("is_last_idle", {63'd0, is_last}, 64'd0);
            if (hold_valid) begin
                chk("hold_in", in, hold.w);
                chk("hold_last", {63'd0, is_last}, {63'd0, hold.l});
                chk("hold_num", {61'd0, byte_num}, {61'd0, hold.n});
            end
            if (in_ready && !buffer_full) begin
                if (expq.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", in);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("word", in, e.w);
                    chk("is_last", {63'd0, is_last}, {63'd0, e.l});
                    if (e.l) chk("byte_num", {61'd0, byte_num}, {61'd0, e.n});
                end
            end
            hold_valid = in_ready && buffer_full;
            hold       = {in, is_last, byte_num};
            if ((byte_valid && byte_ready && byte_last) || (eom && !byte_valid && byte_ready))
                term = 1'b1;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 0;
        byte_valid = 0; byte_last = 0; eom = 0;
        stall_pct = 0; force_stall = 0;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_in", in, 64'd0);
        chk("rst_is_last", {63'd0, is_last}, 64'd0);
        chk("rst_byte_num", {61'd0, byte_num}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_byte_ready", {63'd0, byte_ready}, 64'd1);
        reset = 1'b1;
        expq.delete();
        term = 0;
        hold_valid = 0;
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit last);
        bit acc;
        int budget;
        budget = 0;
        byte_in = b; byte_valid = 1; byte_last = last;
        eom = ($urandom_range(3) == 0);
        forever begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            if (acc) break;
            budget++;
            if (budget > 300) begin
                chk("byte_accept_timeout", 64'(budget), 64'd0);
                break;
            end
        end
        byte_valid = 0; byte_last = 0; eom = 0;
        byte_in = 8'($urandom);
    endtask

    task automatic drive_eom();
        bit acc;
        int budget;
        budget = 0;
        byte_valid = 0; eom = 1;
        forever begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            if (acc) break;
            budget++;
            if (budget > 300) begin
                chk("eom_accept_timeout", 64'(budget), 64'd0);
                break;
            end
        end
        eom = 0;
    endtask

    task automatic finish_msg();
        bit seen;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        @(posedge clk); #1;
        chk("done_reached", {63'd0, seen}, 64'd1);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        // Bytes after completion must be refused.
        for (int i = 0; i < 4; i++) begin
            byte_valid = 1; byte_in = 8'($urandom); byte_last = 1'(i & 1);
            @(negedge clk);
            chk("post_done_ready", {63'd0, byte_ready}, 64'd0);
            chk("post_done_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        byte_valid = 0; byte_last = 0;
    endtask

    task automatic run_msg(input bit use_eom, input int idle_max, input int stall_idx);
        for (int i = 0; i < cur_msg.size(); i++) begin
            idle($urandom_range(idle_max));
            drive_byte(cur_msg[i], !use_eom && (i == cur_msg.size() - 1));
            if (i == stall_idx) force_stall = 5;
        end
        if (use_eom) drive_eom();
        finish_msg();
    endtask

    initial begin
        reset = 0; byte_in = 0; byte_valid = 0; byte_last = 0; eom = 0; buffer_full = 0;

        // Eight bytes, last on the eighth: full word then empty final word.
        do_reset();
        cur_msg.delete();
        for (int i = 1; i <= 8; i++) cur_msg.push_back(8'(i));
        model_push(cur_msg);
        chk("m34_w0", expq[0].w, 64'h0102030405060708);
        chk("m34_l0", {63'd0, expq[0].l}, 64'd0);
        chk("m34_w1", {expq[1].w[62:0], expq[1].l}, 64'd1);
        chk("m34_n1", {61'd0, expq[1].n}, 64'd0);
        run_msg(0, 0, -1);

        // Three bytes, last on the third.
        do_reset();
        cur_msg = '{8'hAA, 8'hBB, 8'hCC};
        model_push(cur_msg);
        chk("m35_w", expq[0].w, 64'hAABBCC0000000000);
        chk("m35_n", {61'd0, expq[0].n}, 64'd3);
        run_msg(0, 0, -1);

        // eom only, straight after reset.
        do_reset();
        cur_msg.delete();
        model_push(cur_msg);
        chk("m36_w", expq[0].w, 64'd0);
        chk("m36_ln", {60'd0, expq[0].l, expq[0].n}, 64'h8);
        run_msg(1, 0, -1);

        // 20 bytes with a 5-cycle stall while word 2 sits in the slot.
        do_reset();
        cur_msg.delete();
        for (int i = 0; i < 20; i++) cur_msg.push_back(8'($urandom));
        model_push(cur_msg);
        chk("m37_l1", {63'd0, expq[1].l}, 64'd0);
        chk("m37_n2", {60'd0, expq[2].l, expq[2].n}, 64'hC);
        run_msg(0, 0, 15);

        // Reset mid-word discards the partial bytes.
        do_reset();
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom), 0);
        do_reset();
        cur_msg = '{8'h11};
        model_push(cur_msg);
        chk("m38_w", expq[0].w, 64'h1100000000000000);
        chk("m38_n", {61'd0, expq[0].n}, 64'd1);
        run_msg(0, 0, -1);

        // Random messages, termination style, idles and back-pressure.
        for (int m = 0; m < 25; m++) begin
            int  len;
            bit  use_eom;
            do_reset();
            len = $urandom_range(30);
            use_eom = (len == 0) || ($urandom_range(1) == 1);
            stall_pct = $urandom_range(60);
            cur_msg.delete();
            for (int i = 0; i < len; i++) cur_msg.push_back(8'($urandom));
            model_push(cur_msg);
            run_msg(use_eom, 2, -1);
        end

        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
